// File: rtl/axis_match_pkg.sv
// axis_match_pkg: shared FSM encoding, match record field layout and output word builders
package axis_match_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, W0 = 2'd2, W1 = 2'd3} state_t;
    localparam int COORD_W = 10;
    localparam int X1_LSB = 0;
    localparam int Y1_LSB = 10;
    localparam int X2_LSB = 20;
    localparam int Y2_LSB = 30;
    localparam int HDR_N_LSB = 0;
    localparam int HDR_FRAME_LSB = 16;
    function automatic logic [31:0] hdr_word(input logic [15:0] frame, input logic [15:0] n);
        return (32'(frame) << HDR_FRAME_LSB) | (32'(n) << HDR_N_LSB);
    endfunction
    function automatic logic [31:0] coord_word(input logic [COORD_W-1:0] y, input logic [COORD_W-1:0] x);
        return {6'd0, y, 6'd0, x};
    endfunction
endpackage

// File: rtl/match_fifo.sv
// match_fifo: synchronous FIFO exposing the head record and the one behind it before any pop
module match_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head,
    output logic [WIDTH-1:0]       head_nxt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = mem[rd_ptr];
    assign head_nxt = mem[rd_ptr + AW'(1)];
    always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/axis_match_tx.sv
// axis_match_tx: buffers a frame's match records and streams them as one AXI-Stream packet per frame
module axis_match_tx
    import axis_match_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             m_axis_aclk,
    input  logic             m_axis_aresetn,
    input  logic             match_valid,
    input  logic [39:0]      match_data,
    input  logic             frame_end,
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state;
    logic [CW-1:0] fifo_cnt, n_now, rem;
    logic [39:0] head, head_nxt, src;
    logic [2*COORD_W-1:0] rec;
    logic full, empty, push, pop, hs, done, drop;
    assign hs = m_axis_tvalid && m_axis_tready;
    assign done = hs && m_axis_tlast;
    assign push = state == IDLE && match_valid && !full;
    assign pop = state == W1 && hs && !empty;
    assign drop = match_valid && !push;
    assign n_now = fifo_cnt + CW'(push);
    assign src = state == W1 ? head_nxt : head;
    match_fifo #(.WIDTH(40), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(m_axis_aclk),
        .rst(!m_axis_aresetn),
        .push(push),
        .din(match_data),
        .pop(pop),
        .full(full),
        .empty(empty),
        .count(fifo_cnt),
        .head(head),
        .head_nxt(head_nxt)
    );
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            state <= IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            m_axis_tkeep <= 4'h0;
            m_axis_tdata <= '0;
            busy <= 1'b0;
            drop_cnt <= '0;
            frame_cnt <= '0;
            rem <= '0;
            rec <= '0;
        end else begin
            if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
            if (done) begin
                state <= IDLE;
                busy <= 1'b0;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast <= 1'b0;
                m_axis_tkeep <= 4'h0;
                m_axis_tdata <= '0;
                frame_cnt <= frame_cnt + 1'b1;
            end else begin
                case (state)
                    IDLE: if (frame_end) begin
                        state <= HDR;
                        busy <= 1'b1;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tkeep <= 4'hF;
                        m_axis_tdata <= hdr_word(16'(frame_cnt), 16'(n_now));
                        m_axis_tlast <= n_now == '0;
                        rem <= n_now;
                    end
                    HDR, W1: if (hs) begin
                        state <= W0;
                        rec <= src[X2_LSB +: 2*COORD_W];
                        m_axis_tdata <= coord_word(src[Y1_LSB +: COORD_W], src[X1_LSB +: COORD_W]);
                        m_axis_tlast <= 1'b0;
                        rem <= rem - CW'(state == W1);
                    end
                    W0: if (hs) begin
                        state <= W1;
                        m_axis_tdata <= coord_word(rec[Y2_LSB-X2_LSB +: COORD_W], rec[0 +: COORD_W]);
                        m_axis_tlast <= rem == CW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
